// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: alternating priority on ties, grants held for the
// whole bus cycle, and an un-acked-strobe timeout that aborts the granted master.
module wb_master_arbiter #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WB_DATA_WIDTH-1:0]   m0_data_i,
  output logic [WB_DATA_WIDTH-1:0]   m0_data_o,
  input  logic [WB_ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                       m0_we_i,
  input  logic                       m0_cyc_i,
  input  logic [WB_DATA_WIDTH/8-1:0] m0_stb_i,
  output logic                       m0_ack_o,
  output logic                       m0_err_o,
  input  logic [WB_DATA_WIDTH-1:0]   m1_data_i,
  output logic [WB_DATA_WIDTH-1:0]   m1_data_o,
  input  logic [WB_ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                       m1_we_i,
  input  logic                       m1_cyc_i,
  input  logic [WB_DATA_WIDTH/8-1:0] m1_stb_i,
  output logic                       m1_ack_o,
  output logic                       m1_err_o,
  output logic [WB_DATA_WIDTH-1:0]   wb_data_o,
  output logic [WB_ADDR_WIDTH-1:0]   wb_addr_o,
  output logic                       wb_we_o,
  output logic                       wb_cyc_o,
  output logic [WB_DATA_WIDTH/8-1:0] wb_stb_o,
  input  logic [WB_DATA_WIDTH-1:0]   wb_data_i,
  input  logic                       wb_ack_i,
  output logic [1:0]                 grant_o,
  output logic [15:0]                err_count_o
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} arbState_t;

  arbState_t   state_q, state_d;
  logic        lastGrant_q, lastGrant_d;
  logic        abortOwner_q, abortOwner_d;
  logic        errPulse_q, errPulse_d;
  logic [15:0] timeout_q, timeout_d;
  logic [15:0] errCount_q, errCount_d;

  logic        activeMaster;
  logic        activeCyc;
  logic        activeStbAny;

  // The master currently holding the bus (granted or being aborted), 0 or 1.
  assign activeMaster = (state_q == GRANT1) || ((state_q == ABORT) && abortOwner_q);
  assign activeCyc    = activeMaster ? m1_cyc_i : m0_cyc_i;
  assign activeStbAny = activeMaster ? (|m1_stb_i) : (|m0_stb_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      lastGrant_q  <= 1'b1;
      abortOwner_q <= 1'b0;
      errPulse_q   <= 1'b0;
      timeout_q    <= '0;
      errCount_q   <= '0;
    end else begin
      state_q      <= state_d;
      lastGrant_q  <= lastGrant_d;
      abortOwner_q <= abortOwner_d;
      errPulse_q   <= errPulse_d;
      timeout_q    <= timeout_d;
      errCount_q   <= errCount_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lastGrant_d  = lastGrant_q;
    abortOwner_d = abortOwner_q;
    errPulse_d   = 1'b0;
    timeout_d    = timeout_q;
    errCount_d   = errCount_q;
    case (state_q)
      IDLE: begin
        timeout_d = '0;
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = lastGrant_q ? GRANT0 : GRANT1;
        end else if (m0_cyc_i) begin
          state_d = GRANT0;
        end else if (m1_cyc_i) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (!activeCyc) begin
          state_d     = IDLE;
          lastGrant_d = activeMaster;
          timeout_d   = '0;
        end else if (wb_ack_i) begin
          timeout_d = '0;
        end else if (activeStbAny) begin
          // An ack on the reaching cycle is handled above, so it always wins.
          if (timeout_q == TIMEOUT_LAST) begin
            state_d      = ABORT;
            abortOwner_d = activeMaster;
            errPulse_d   = 1'b1;
            timeout_d    = '0;
            if (errCount_q != 16'hFFFF) begin
              errCount_d = errCount_q + 16'd1;
            end
          end else begin
            timeout_d = timeout_q + 16'd1;
          end
        end
      end
      ABORT: begin
        if (!activeCyc) begin
          state_d     = IDLE;
          lastGrant_d = abortOwner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_data_o   = '0;
    wb_addr_o   = '0;
    wb_we_o     = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = '0;
    m0_ack_o    = 1'b0;
    m0_data_o   = '0;
    m1_ack_o    = 1'b0;
    m1_data_o   = '0;
    if (state_q == GRANT0) begin
      wb_data_o = m0_data_i;
      wb_addr_o = m0_addr_i;
      wb_we_o   = m0_we_i;
      wb_cyc_o  = m0_cyc_i;
      wb_stb_o  = m0_stb_i;
      m0_ack_o  = wb_ack_i;
      m0_data_o = wb_data_i;
    end else if (state_q == GRANT1) begin
      wb_data_o = m1_data_i;
      wb_addr_o = m1_addr_i;
      wb_we_o   = m1_we_i;
      wb_cyc_o  = m1_cyc_i;
      wb_stb_o  = m1_stb_i;
      m1_ack_o  = wb_ack_i;
      m1_data_o = wb_data_i;
    end
    grant_o[0]  = (state_q == GRANT0) || ((state_q == ABORT) && !abortOwner_q);
    grant_o[1]  = (state_q == GRANT1) || ((state_q == ABORT) && abortOwner_q);
    m0_err_o    = errPulse_q && !abortOwner_q;
    m1_err_o    = errPulse_q && abortOwner_q;
    err_count_o = errCount_q;
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: directed scenarios then random traffic,
// all compared against a transaction-level model of owner / wait count / error count.
module tb_wb_master_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] m0_data_i, m0_data_o, m1_data_i, m1_data_o;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic          m0_we_i, m0_cyc_i, m0_ack_o, m0_err_o;
  logic          m1_we_i, m1_cyc_i, m1_ack_o, m1_err_o;
  logic [SW-1:0] m0_stb_i, m1_stb_i;
  logic [DW-1:0] wb_data_o, wb_data_i;
  logic [AW-1:0] wb_addr_o;
  logic          wb_we_o, wb_cyc_o, wb_ack_i;
  logic [SW-1:0] wb_stb_o;
  logic [1:0]    grant_o;
  logic [15:0]   err_count_o;

  wb_master_arbiter #(
    .WB_DATA_WIDTH (DW),
    .WB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_addr_i(m0_addr_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_addr_i(m1_addr_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_data_i(wb_data_i),
    .wb_ack_i(wb_ack_i), .grant_o(grant_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus, whether that ownership is being aborted,
  // how long the owner has waited without an ack, and the abort tally.
  int owner;
  int lastGrant;
  int waitCnt;
  int errCnt;
  int errWho;
  bit aborting;
  bit errFlag;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    owner     = -1;
    lastGrant = 1;
    waitCnt   = 0;
    errCnt    = 0;
    errWho    = 0;
    aborting  = 1'b0;
    errFlag   = 1'b0;
  endtask

  // One clock edge of arbitration, evaluated from the inputs held across that edge.
  task automatic modelStep();
    bit c[2];
    bit s[2];
    c[0] = m0_cyc_i;
    c[1] = m1_cyc_i;
    s[0] = |m0_stb_i;
    s[1] = |m1_stb_i;
    errFlag = 1'b0;
    if (owner < 0) begin
      if (c[0] && c[1]) owner = (lastGrant == 1) ? 0 : 1;
      else if (c[0]) owner = 0;
      else if (c[1]) owner = 1;
      waitCnt = 0;
    end else if (!c[owner]) begin
      lastGrant = owner;
      owner     = -1;
      aborting  = 1'b0;
    end else if (!aborting) begin
      if (wb_ack_i) begin
        waitCnt = 0;
      end else if (s[owner]) begin
        waitCnt++;
        if (waitCnt == TO) begin
          aborting = 1'b1;
          errFlag  = 1'b1;
          errWho   = owner;
          waitCnt  = 0;
          if (errCnt < 65535) errCnt++;
        end
      end
    end
  endtask

  task automatic compareAll();
    bit g0, g1;
    logic [31:0] expGrant;
    g0 = (owner == 0) && !aborting;
    g1 = (owner == 1) && !aborting;
    expGrant = (owner < 0) ? 32'd0 : ((owner == 0) ? 32'd1 : 32'd2);
    checkOutput("grant", 32'(grant_o), expGrant);
    checkOutput("wbCyc", 32'(wb_cyc_o), g0 ? 32'(m0_cyc_i) : g1 ? 32'(m1_cyc_i) : 32'd0);
    checkOutput("wbWe", 32'(wb_we_o), g0 ? 32'(m0_we_i) : g1 ? 32'(m1_we_i) : 32'd0);
    checkOutput("wbStb", 32'(wb_stb_o), g0 ? 32'(m0_stb_i) : g1 ? 32'(m1_stb_i) : 32'd0);
    checkOutput("wbAddr", 32'(wb_addr_o), g0 ? 32'(m0_addr_i) : g1 ? 32'(m1_addr_i) : 32'd0);
    checkOutput("wbData", 32'(wb_data_o), g0 ? 32'(m0_data_i) : g1 ? 32'(m1_data_i) : 32'd0);
    checkOutput("m0Ack", 32'(m0_ack_o), g0 ? 32'(wb_ack_i) : 32'd0);
    checkOutput("m1Ack", 32'(m1_ack_o), g1 ? 32'(wb_ack_i) : 32'd0);
    checkOutput("m0Data", 32'(m0_data_o), g0 ? 32'(wb_data_i) : 32'd0);
    checkOutput("m1Data", 32'(m1_data_o), g1 ? 32'(wb_data_i) : 32'd0);
    checkOutput("m0Err", 32'(m0_err_o), (errFlag && errWho == 0) ? 32'd1 : 32'd0);
    checkOutput("m1Err", 32'(m1_err_o), (errFlag && errWho == 1) ? 32'd1 : 32'd0);
    checkOutput("errCount", 32'(err_count_o), 32'(errCnt));
  endtask

  // Drive one cycle of master/slave inputs, clock it, then check all outputs.
  task automatic applyStimulus(input bit c0, input bit c1, input logic [SW-1:0] s0,
                               input logic [SW-1:0] s1, input bit ack);
    m0_cyc_i  = c0;
    m1_cyc_i  = c1;
    m0_stb_i  = s0;
    m1_stb_i  = s1;
    wb_ack_i  = ack;
    m0_we_i   = 1'($urandom());
    m1_we_i   = 1'($urandom());
    m0_data_i = $urandom();
    m1_data_i = $urandom();
    m0_addr_i = $urandom();
    m1_addr_i = $urandom();
    wb_data_i = $urandom();
    @(posedge clk);
    modelStep();
    #2;
    compareAll();
  endtask

  initial begin
    int prevOwner;
    int age;
    bit c0, c1;
    rst = 1'b1;
    m0_cyc_i = 0; m1_cyc_i = 0; m0_stb_i = '0; m1_stb_i = '0;
    m0_we_i = 0; m1_we_i = 0; m0_data_i = '0; m1_data_i = '0;
    m0_addr_i = '0; m1_addr_i = '0; wb_data_i = '0; wb_ack_i = 0;
    modelReset();
    #2;
    checkOutput("rstGrant", 32'(grant_o), 32'd0);
    checkOutput("rstCyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("rstErrCount", 32'(err_count_o), 32'd0);
    #15 rst = 1'b0;

    // Simultaneous request after reset: m0 first, then m1 after an idle cycle.
    applyStimulus(1, 1, 4'hF, 4'hF, 0);
    applyStimulus(1, 1, 4'hF, 4'hF, 1);
    checkOutput("tieFirstGrant", 32'(grant_o), 32'd1);
    applyStimulus(0, 1, 4'h0, 4'hF, 0);
    applyStimulus(0, 1, 4'h0, 4'hF, 0);
    applyStimulus(0, 1, 4'h0, 4'hF, 1);
    checkOutput("tieSecondGrant", 32'(grant_o), 32'd2);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);

    // Both masters requesting continuously, each releasing after one acked cycle.
    prevOwner = -1;
    age = 0;
    for (int i = 0; i < 16; i++) begin
      age = (owner == prevOwner && owner >= 0) ? age + 1 : 0;
      prevOwner = owner;
      applyStimulus(!(owner == 0 && age >= 1), !(owner == 1 && age >= 1), 4'h3, 4'hC, 1);
    end
    applyStimulus(0, 0, 4'h0, 4'h0, 0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);

    // m1 alone, slave silent: abort after TO un-acked cycles.
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 4'h0, 4'hF, 0);
    checkOutput("timeoutErrCount", 32'(err_count_o), 32'd1);
    checkOutput("timeoutCycLow", 32'(wb_cyc_o), 32'd0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);

    // m1 alone, ack arrives on the reaching cycle: no abort.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 4'h0, 4'hF, 0);
    applyStimulus(0, 1, 4'h0, 4'hF, 1);
    checkOutput("lateAckSeen", 32'(m1_ack_o), 32'd1);
    checkOutput("lateAckErrCount", 32'(err_count_o), 32'd1);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);

    // m0 burst of four acked writes while m1 keeps requesting.
    applyStimulus(1, 1, 4'hF, 4'hF, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 4'hF, 4'hF, 1);
      checkOutput("burstGrant", 32'(grant_o), 32'd1);
      checkOutput("burstM1Ack", 32'(m1_ack_o), 32'd0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 4'h0, 4'hF, 1);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);

    // Asynchronous reset in the middle of a GRANT0 cycle.
    applyStimulus(1, 0, 4'hF, 4'h0, 0);
    applyStimulus(1, 0, 4'hF, 4'h0, 1);
    rst = 1'b1;
    #1;
    checkOutput("asyncRstCyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("asyncRstGrant", 32'(grant_o), 32'd0);
    checkOutput("asyncRstErrCount", 32'(err_count_o), 32'd0);
    modelReset();
    #2 rst = 1'b0;
    applyStimulus(1, 0, 4'hF, 4'h0, 1);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);
    applyStimulus(0, 0, 4'h0, 4'h0, 0);

    // Random traffic with sticky requests and a sparse slave.
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 15) c0 = !c0;
      if ($urandom_range(0, 99) < 15) c1 = !c1;
      applyStimulus(c0, c1,
                    ($urandom_range(0, 3) == 0) ? 4'h0 : SW'($urandom_range(1, 15)),
                    ($urandom_range(0, 3) == 0) ? 4'h0 : SW'($urandom_range(1, 15)),
                    $urandom_range(0, 99) < 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter WB_DATA_WIDTH, default 32, SHALL set the data bus width; stb/select width is WB_DATA_WIDTH/8.
REQ-002 Parameter WB_ADDR_WIDTH, default 32, SHALL set the full master address width, passed to the interconnect unmodified.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 2..65535, SHALL set the number of un-acked cycles before abort.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 mN_data_i  in  WB_DATA_WIDTH  write data from master N (N = 0, 1).
REQ-007 mN_data_o  out  WB_DATA_WIDTH  read data to master N.
REQ-008 mN_addr_i  in  WB_ADDR_WIDTH  address from master N.
REQ-009 mN_we_i  in  1  write enable from master N.
REQ-010 mN_cyc_i  in  1  bus cycle request from master N.
REQ-011 mN_stb_i  in  WB_DATA_WIDTH/8  byte strobes from master N.
REQ-012 mN_ack_o  out  1  acknowledge to master N.
REQ-013 mN_err_o  out  1  timeout error pulse to master N.
REQ-014 wb_data_o, wb_addr_o, wb_we_o, wb_cyc_o, wb_stb_o  out  (widths as master side)  shared port to the interconnect.
REQ-015 wb_data_i  in  WB_DATA_WIDTH; wb_ack_i  in  1  read data / ack from the interconnect.
REQ-016 grant_o  out  2  one-hot current grant {m1, m0}; 00 when none.
REQ-017 err_count_o  out  16  saturating count of timeout aborts.

Function
REQ-018 FSM states SHALL be IDLE, GRANT0, GRANT1, ABORT; state, last_grant, timeout counter and err_count are registers.
REQ-019 IDLE: only m0_cyc_i -> GRANT0; only m1_cyc_i -> GRANT1; both -> grant the master not equal to last_grant; neither -> stay.
REQ-020 Grant latency SHALL be exactly one cycle from mN_cyc_i rising in IDLE to wb_cyc_o high.
REQ-021 In GRANTn, wb_data_o/addr/we/stb SHALL follow master n combinationally and wb_cyc_o = mn_cyc_i.
REQ-022 Outside GRANTn, wb_cyc_o, wb_we_o, wb_stb_o SHALL be 0; wb_data_o and wb_addr_o 0.
REQ-023 mn_ack_o = wb_ack_i and mn_data_o = wb_data_i only in GRANTn; the non-granted master sees ack 0, data 0.
REQ-024 Grant SHALL persist across multiple acked transfers while mn_cyc_i stays high (block/RMW cycles not interrupted).
REQ-025 GRANTn with mn_cyc_i = 0 -> IDLE next cycle, last_grant <= n; no back-to-back grant without one IDLE cycle.
REQ-026 Timeout counter SHALL clear on entry to GRANTn and on every wb_ack_i, increment each GRANTn cycle with cyc=1, stb!=0, ack=0.
REQ-027 Counter reaching TIMEOUT_CYCLES SHALL, same edge, go to ABORT and pulse mn_err_o high for exactly one cycle (first ABORT cycle); ack never coincides with err.
REQ-028 wb_ack_i on the timeout-reaching cycle SHALL win: transfer completes, no abort.
REQ-029 ABORT: wb_cyc_o forced 0; wait until mn_cyc_i = 0, then IDLE with last_grant <= n.
REQ-030 err_count_o SHALL increment by 1 per abort and saturate at 16'hFFFF.
REQ-031 grant_o = 01 in GRANT0/ABORT-of-0, 10 in GRANT1/ABORT-of-1, 00 in IDLE.

Reset
REQ-032 rst_i high SHALL immediately (no clock) force IDLE, last_grant = 1 (m0 wins first tie), counter 0, err_count_o 0, all wb_* and mN_ack_o/err_o outputs 0, grant_o 00.
REQ-033 Reset mid-transfer SHALL drop wb_cyc_o asynchronously; after release arbitration restarts from IDLE.

Verification
REQ-034 Both cyc rise same cycle after reset -> GRANT0 one cycle later (grant_o=01); m0 drops cyc -> IDLE, then GRANT1 (grant_o=10).
REQ-035 Both masters hold cyc continuously, each releasing after one ack -> grants alternate 0,1,0,1 with one IDLE cycle between.
REQ-036 m0 burst of 4 acked writes, m1 requesting throughout -> m1 ack_o stays 0, grant holds 0 until m0 cyc drops.
REQ-037 TIMEOUT_CYCLES=4, slave never acks m1 -> m1_err_o one-cycle pulse after 4 un-acked cycles, wb_cyc_o low, err_count_o=1.
REQ-038 TIMEOUT_CYCLES=4, ack on 4th cycle -> m1_ack_o=1, no err, err_count_o unchanged.
REQ-039 rst_i asserted mid-GRANT0 between clock edges -> wb_cyc_o and grant_o go 0 before next edge; err_count_o=0.
